// File: rtl/checker_mem_pkg.sv
// Shared types and constants for the dual-port checker memory.
// Build option: CHECKER_MEM_OUTREG_EN adds one output register per port (read latency 2 instead of 1).
package checker_mem_pkg;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    localparam int LANE_W = 8;

`ifdef CHECKER_MEM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/checker_mem_port.sv
// One access port: request qualification, lane write mask, read-first data capture, optional output stage.
// Build option: CHECKER_MEM_OUTREG_EN inserts the extra output register.
module checker_mem_port
    import checker_mem_pkg::*;
#(
    parameter int DW  = 32,
    parameter int WAW = 11,
    localparam int NB  = DW / LANE_W,
    localparam int LSB = $clog2(NB),
    localparam int BAW = WAW + LSB
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_ready,
    input  logic           i_en,
    input  logic [NB-1:0]  i_we,
    input  logic [BAW-1:0] i_addr,
    input  logic [DW-1:0]  i_rdata,
    output logic [WAW-1:0] o_idx,
    output logic [NB-1:0]  o_wmask,
    output logic [DW-1:0]  o_dout,
    output logic           o_valid
);

    logic          w_acc;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;

    assign w_acc   = i_en & i_ready;
    assign o_idx   = i_addr[BAW-1:LSB];
    assign o_wmask = i_we & {NB{w_acc}};

    generate
        if (LSB > 0) begin : g_lsb
            logic w_unused_lsb;
            assign w_unused_lsb = ^i_addr[LSB-1:0];
        end
    endgenerate

    // i_rdata is the array word before this edge's write, which gives read-first behaviour.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_acc;
            if (w_acc) r_rd_data <= i_rdata;
        end
    end

`ifdef CHECKER_MEM_OUTREG_EN
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_rd_valid;
            if (r_rd_valid) r_out_data <= r_rd_data;
        end
    end

    assign o_dout  = r_out_data;
    assign o_valid = r_out_valid;
`else
    assign o_dout  = r_rd_data;
    assign o_valid = r_rd_valid;
`endif

endmodule

// File: rtl/checker_memory_dp.sv
// True-dual-port byte-lane scratch memory with port-A lane priority and a hardware clear engine.
// Build option: CHECKER_MEM_OUTREG_EN selects read latency 2 (undefined: latency 1).
module checker_memory_dp
    import checker_mem_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 2048,
    localparam int NB  = DW / LANE_W,
    localparam int WAW = $clog2(DEPTH),
    localparam int BAW = $clog2(DEPTH * NB)
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           a_en,
    input  logic [NB-1:0]  a_we,
    input  logic [BAW-1:0] a_addr,
    input  logic [DW-1:0]  a_din,
    output logic [DW-1:0]  a_dout,
    output logic           a_valid,
    input  logic           b_en,
    input  logic [NB-1:0]  b_we,
    input  logic [BAW-1:0] b_addr,
    input  logic [DW-1:0]  b_din,
    output logic [DW-1:0]  b_dout,
    output logic           b_valid,
    input  logic           clr_start,
    output logic           clr_busy,
    output logic           ready,
    output clr_state_t     dbg_clr_state
);

    logic [DW-1:0]  r_mem [DEPTH];
    logic [WAW-1:0] w_a_idx, w_b_idx;
    logic [NB-1:0]  w_a_wmask, w_b_wmask;
    clr_state_t     r_state, w_state_nxt;
    logic [WAW-1:0] r_cnt, w_cnt_nxt;

    assign clr_busy      = (r_state == CLR_RUN);
    assign ready         = ~clr_busy;
    assign dbg_clr_state = r_state;

    checker_mem_port #(.DW(DW), .WAW(WAW)) u_port_a (
        .i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_ready(ready),
        .i_en(a_en), .i_we(a_we), .i_addr(a_addr), .i_rdata(r_mem[w_a_idx]),
        .o_idx(w_a_idx), .o_wmask(w_a_wmask), .o_dout(a_dout), .o_valid(a_valid)
    );

    checker_mem_port #(.DW(DW), .WAW(WAW)) u_port_b (
        .i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_ready(ready),
        .i_en(b_en), .i_we(b_we), .i_addr(b_addr), .i_rdata(r_mem[w_b_idx]),
        .o_idx(w_b_idx), .o_wmask(w_b_wmask), .o_dout(b_dout), .o_valid(b_valid)
    );

    // Port A lanes are written last so they override B on a shared word and lane.
    always_ff @(posedge sys_clk) begin
        if (clr_busy) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_b_wmask[i]) r_mem[w_b_idx][i*LANE_W +: LANE_W] <= b_din[i*LANE_W +: LANE_W];
            end
            for (int i = 0; i < NB; i++) begin
                if (w_a_wmask[i]) r_mem[w_a_idx][i*LANE_W +: LANE_W] <= a_din[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= CLR_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CLR_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = CLR_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            CLR_RUN: begin
                if (r_cnt == WAW'(DEPTH - 1)) begin
                    w_state_nxt = CLR_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + WAW'(1);
                end
            end
            default: w_state_nxt = CLR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_checker_memory_dp.sv
// Directed scoreboard bench for checker_memory_dp (DW=32, DEPTH=2048); honours CHECKER_MEM_OUTREG_EN.
module tb_checker_memory_dp;
    import checker_mem_pkg::*;

`ifdef CHECKER_MEM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_en = 1'b0, b_en = 1'b0, clr_start = 1'b0;
    logic [3:0]  a_we = '0, b_we = '0;
    logic [12:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_din = '0, b_din = '0;
    logic [31:0] a_dout, b_dout;
    logic        a_valid, b_valid, clr_busy, ready;
    clr_state_t  dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_cnt;
    logic [31:0] exp_a_q[$], exp_b_q[$];
    int          exp_a_t[$], exp_b_t[$];

    checker_memory_dp #(.DW(32), .DEPTH(2048)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_valid(a_valid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_valid(b_valid),
        .clr_start(clr_start), .clr_busy(clr_busy), .ready(ready), .dbg_clr_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        a_en = 0; a_we = '0; b_en = 0; b_we = '0; clr_start = 0;
    endtask

    // One request cycle on both ports; expected returned words are pushed for the monitors.
    task automatic req(input logic ae, input logic [3:0] awe, input logic [12:0] aad,
                       input logic [31:0] adi, input logic [31:0] aexp,
                       input logic be, input logic [3:0] bwe, input logic [12:0] bad_,
                       input logic [31:0] bdi, input logic [31:0] bexp, input logic cs);
        @(posedge clk); #1;
        a_en = ae; a_we = awe; a_addr = aad; a_din = adi;
        b_en = be; b_we = bwe; b_addr = bad_; b_din = bdi;
        clr_start = cs;
        if (ae) begin exp_a_q.push_back(aexp); exp_a_t.push_back(cyc + L); end
        if (be) begin exp_b_q.push_back(bexp); exp_b_t.push_back(cyc + L); end
    endtask

    // scoreboard monitors: data and arrival cycle
    always @(negedge clk) begin
        if (rst_n && a_valid) begin
            total++;
            if (exp_a_q.size() == 0) begin
                bad++;
                $display("FAIL a_rd: unexpected valid data %h at cycle %0d, want none", a_dout, cyc);
            end else begin
                logic [31:0] e;
                int t;
                e = exp_a_q.pop_front();
                t = exp_a_t.pop_front();
                if (a_dout !== e || cyc != t) begin
                    bad++;
                    $display("FAIL a_rd: got %h at cycle %0d, want %h at cycle %0d", a_dout, cyc, e, t);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_valid) begin
            total++;
            if (exp_b_q.size() == 0) begin
                bad++;
                $display("FAIL b_rd: unexpected valid data %h at cycle %0d, want none", b_dout, cyc);
            end else begin
                logic [31:0] e;
                int t;
                e = exp_b_q.pop_front();
                t = exp_b_t.pop_front();
                if (b_dout !== e || cyc != t) begin
                    bad++;
                    $display("FAIL b_rd: got %h at cycle %0d, want %h at cycle %0d", b_dout, cyc, e, t);
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_dout", a_dout, 32'h0);
        chk("rst_b_dout", b_dout, 32'h0);
        chk("rst_valids", {30'd0, a_valid, b_valid}, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'h1);
        chk("rst_busy", {31'd0, clr_busy}, 32'h0);
        chk("rst_state", {31'd0, dbg_state}, {31'd0, CLR_IDLE});
        @(negedge clk) rst_n = 1'b1;

        // full clear: busy length and dropped requests
        req(0, 4'h0, 13'h0, 32'h0, 32'h0, 0, 4'h0, 13'h0, 32'h0, 32'h0, 1);
        idle();
        busy_cnt = 0;
        while (1) begin
            @(negedge clk);
            if (!clr_busy) break;
            busy_cnt++;
            if (busy_cnt == 500) begin
                a_en = 1; a_we = 4'hF; a_addr = 13'h00C; a_din = 32'hFFFF_FFFF;
                b_en = 1; b_we = 4'h0; b_addr = 13'h01C;
            end
            if (busy_cnt == 501) begin
                chk("ready_busy", {31'd0, ready}, 32'h0);
                a_en = 0; a_we = '0; b_en = 0;
            end
            if (busy_cnt > 3000) break;
        end
        chk("busy_len", busy_cnt, 32'd2048);

        // memory reads zero after clear; word 3 write during clear was dropped
        req(1, 4'h0, 13'h00C, 32'h0, 32'h0, 1, 4'h0, 13'h1FFC, 32'h0, 32'h0, 0);
        req(1, 4'h0, 13'h0000, 32'h0, 32'h0, 0, 4'h0, 13'h0, 32'h0, 32'h0, 0);

        // byte-lane writes, read-first, back-to-back
        req(1, 4'hF, 13'h010, 32'hDEAD_BEEF, 32'h0, 0, 4'h0, 13'h0, 32'h0, 32'h0, 0);
        req(1, 4'b0010, 13'h013, 32'h0000_AA00, 32'hDEAD_BEEF, 0, 4'h0, 13'h0, 32'h0, 32'h0, 0);
        req(0, 4'h0, 13'h0, 32'h0, 32'h0, 1, 4'h0, 13'h010, 32'h0, 32'hDEAD_AAEF, 0);

        // cross-port write collision on word 5
        req(1, 4'b0011, 13'h014, 32'h1111_1111, 32'h0, 1, 4'b0110, 13'h016, 32'h2222_2222, 32'h0, 0);
        req(1, 4'h0, 13'h014, 32'h0, 32'h0022_1111, 0, 4'h0, 13'h0, 32'h0, 32'h0, 0);

        // cross-port write/read on word 7
        req(1, 4'hF, 13'h01C, 32'h1234_5678, 32'h0, 1, 4'h0, 13'h01C, 32'h0, 32'h0, 0);
        req(0, 4'h0, 13'h0, 32'h0, 32'h0, 1, 4'h0, 13'h01C, 32'h0, 32'h1234_5678, 0);

        // clear with requests in the start cycle, then reset at cnt=100
        req(1, 4'hF, 13'h1FE0, 32'h5A5A_5A5A, 32'h0, 1, 4'h0, 13'h01C, 32'h0, 32'h1234_5678, 1);
        idle();
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, clr_busy}, 32'h0);
        chk("mid_ready", {31'd0, ready}, 32'h1);
        chk("mid_valids", {30'd0, a_valid, b_valid}, 32'h0);
        chk("mid_b_dout", b_dout, 32'h0);
        @(posedge clk); #1;
        chk("mid_busy_edge", {31'd0, clr_busy}, 32'h0);
        chk("mid_state", {31'd0, dbg_state}, {31'd0, CLR_IDLE});
        @(negedge clk) rst_n = 1'b1;

        req(1, 4'h0, 13'h1FE0, 32'h0, 32'h5A5A_5A5A, 1, 4'h0, 13'h01C, 32'h0, 32'h0, 0);
        req(1, 4'h0, 13'h018C, 32'h0, 32'h0, 0, 4'h0, 13'h0, 32'h0, 32'h0, 0);
        idle();
        repeat (5) @(posedge clk);
        #1;
        chk("a_left", exp_a_q.size(), 32'd0);
        chk("b_left", exp_b_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 time units, want finish earlier");
        $fatal(1);
    end

endmodule
